mod_reduce_accumulator_ctrl: RTL and testbench

- Sequencer that streams a run of NTT_NUMBER-lane coefficient vectors through a pipelined modular adder tree.
- Accumulates the per-beat lane sums modulo MODULUS and returns one scalar result per job.
- Sits between an NTT output buffer (producer of lane vectors) and the scalar result consumer (key-switch and accumulator path).
- One job is: start, N input beats, one output handshake.

---
 rtl/mod_reduce_accumulator_ctrl_pkg.sv | 51 +++++
 rtl/mod_add_tree_pipe.sv | 57 +++++
 rtl/mod_reduce_accumulator_ctrl.sv | 146 ++++++++++++++
 tb/tb_mod_reduce_accumulator_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_reduce_accumulator_ctrl_pkg.sv
// Shared definitions for the modular reduce/accumulate slice.
//   - Build defaults NTT_NUMBER, DATA_SIZE_ARB, MODULUS (overridable by
//     defining the macros before this file is compiled).
//   - FSM state encoding for the controller.
//   - modadd(): compare-subtract modular addition, used by both the lane
//     tree and the accumulator.
// Optional feature macro used by the controller: MOD_REDUCE_RANGE_CHECK_EN.

`ifndef NTT_NUMBER
`define NTT_NUMBER 8
`endif
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 14
`endif
`ifndef MODULUS
`define MODULUS 12289
`endif

package mod_reduce_accumulator_ctrl_pkg;

  localparam int NTT_NUMBER    = `NTT_NUMBER;
  localparam int DATA_SIZE_ARB = `DATA_SIZE_ARB;
  localparam int MODULUS       = `MODULUS;

  // Working width of modadd; callers size-cast operands in and the result out.
  // Operands must be below 2^(MODADD_W-2) so the sum and sign stay exact.
  localparam int MODADD_W = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DRAIN  = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  // (a + b) mod q for a, b < q: subtract q once if the sum reaches q.
  // The sign of the widened difference selects between s and s - q, which
  // matches a DW+2-bit compare for any a, b < 2^DW.
  function automatic logic [MODADD_W-1:0] modadd(
    input logic [MODADD_W-1:0] a,
    input logic [MODADD_W-1:0] b,
    input logic [MODADD_W-1:0] q
  );
    logic [MODADD_W-1:0] s;
    logic [MODADD_W:0]   t;
    s = a + b;
    t = {1'b0, s} - {1'b0, q};
    return t[MODADD_W] ? s : t[MODADD_W-1:0];
  endfunction

endpackage

// File: rtl/mod_add_tree_pipe.sv
// NTT_NUM-lane modular reduction tree with a single output register.
//   clk, rst_n : clock, synchronous active-low reset (valid bit only)
//   in_vld     : lane vector on in_data is valid this cycle
//   in_data    : NTT_NUM lanes, lane k at [DW*k +: DW], each lane < Q
//   out_vld    : registered valid, one cycle after in_vld
//   out_data   : registered sum of all lanes mod Q

module mod_add_tree_pipe
  import mod_reduce_accumulator_ctrl_pkg::*;
#(
  parameter int NTT_NUM = `NTT_NUMBER,
  parameter int DW      = `DATA_SIZE_ARB,
  parameter int Q       = `MODULUS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_vld,
  input  logic [NTT_NUM*DW-1:0] in_data,
  output logic                  out_vld,
  output logic [DW-1:0]         out_data
);

  // Heap-ordered tree: leaves at NTT_NUM..2*NTT_NUM-1, node i sums its
  // children 2i and 2i+1, root at node 1. Filling from the top index down
  // guarantees children are computed before their parent.
  logic [DW-1:0] node [1:2*NTT_NUM-1];

  always_comb begin
    for (int k = 0; k < NTT_NUM; k++) begin
      node[NTT_NUM+k] = in_data[DW*k +: DW];
    end
    for (int i = NTT_NUM - 1; i >= 1; i--) begin
      node[i] = DW'(modadd(MODADD_W'(node[2*i]), MODADD_W'(node[2*i+1]),
                           MODADD_W'(Q)));
    end
  end

  logic          vld_p1;
  logic [DW-1:0] sum_p1;

  // Stage 1: tree output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= in_vld;
    end
  end

  always_ff @(posedge clk) begin
    sum_p1 <= node[1];
  end

  assign out_vld  = vld_p1;
  assign out_data = sum_p1;

endmodule

// File: rtl/mod_reduce_accumulator_ctrl.sv
// Job sequencer: streams num_beats lane vectors through the modular adder
// tree, accumulates the beat sums mod Q and returns one scalar per job.
//   clk, rst_n            : clock, synchronous active-low reset
//   start, num_beats      : job start (sampled in IDLE) and its beat count
//   busy                  : high in every state except IDLE
//   in_valid/in_ready/in_data   : lane-vector input handshake
//   out_valid/out_ready/out_data: scalar result handshake
//   range_err             : only with MOD_REDUCE_RANGE_CHECK_EN defined;
//                           sticky flag for any accepted lane >= Q,
//                           cleared by the next accepted start.

module mod_reduce_accumulator_ctrl
  import mod_reduce_accumulator_ctrl_pkg::*;
#(
  parameter int NTT_NUM = `NTT_NUMBER,
  parameter int DW      = `DATA_SIZE_ARB,
  parameter int Q       = `MODULUS,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_W-1:0]      num_beats,
  output logic                  busy,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NTT_NUM*DW-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
`ifdef MOD_REDUCE_RANGE_CHECK_EN
  output logic                  range_err,
`endif
  output logic [DW-1:0]         out_data
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  rem_q;
  logic              in_fire;
  logic              start_fire;
  logic              last_fire;
  logic              vld_p1;
  logic [DW-1:0]     sum_p1;
  logic [DW-1:0]     acc_p2;

  assign in_ready   = (state_q == ACCUM);
  assign in_fire    = in_valid && in_ready;
  assign start_fire = start && (state_q == IDLE);
  assign last_fire  = in_fire && (rem_q == CNT_W'(1));

  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == OUTPUT);
  assign out_data  = acc_p2;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (num_beats == '0) ? OUTPUT : ACCUM;
        end
      end
      ACCUM: begin
        if (last_fire) begin
          state_d = DRAIN;
        end
      end
      // No beat can enter while draining, so once the tree register is
      // empty the accumulator has already absorbed the final beat.
      DRAIN: begin
        if (!vld_p1) begin
          state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start_fire) begin
        rem_q <= num_beats;
      end else if (in_fire && (rem_q != '0)) begin
        rem_q <= rem_q - CNT_W'(1);
      end
    end
  end

  // Stage 1: lane tree, registered at its output
  mod_add_tree_pipe #(
    .NTT_NUM (NTT_NUM),
    .DW      (DW),
    .Q       (Q)
  ) u_tree (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (in_fire),
    .in_data  (in_data),
    .out_vld  (vld_p1),
    .out_data (sum_p1)
  );

  // Stage 2: accumulator; it doubles as the held result in OUTPUT
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_p2 <= '0;
    end else if (start_fire) begin
      acc_p2 <= '0;
    end else if (vld_p1) begin
      acc_p2 <= DW'(modadd(MODADD_W'(acc_p2), MODADD_W'(sum_p1),
                           MODADD_W'(Q)));
    end
  end

`ifdef MOD_REDUCE_RANGE_CHECK_EN
  logic lane_oor;

  always_comb begin
    lane_oor = 1'b0;
    for (int k = 0; k < NTT_NUM; k++) begin
      if (in_data[DW*k +: DW] >= DW'(Q)) begin
        lane_oor = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      range_err <= 1'b0;
    end else if (start_fire) begin
      range_err <= 1'b0;
    end else if (in_fire && lane_oor) begin
      range_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mod_reduce_accumulator_ctrl.sv
// Directed + randomized bench for mod_reduce_accumulator_ctrl.
// Reference: the job result is the plain integer sum of every lane of every
// beat, reduced mod Q once at the end.

module tb_mod_reduce_accumulator_ctrl;

  localparam int N  = 8;
  localparam int DW = 14;
  localparam int Q  = 12289;
  localparam int CW = 16;

  typedef logic [N*DW-1:0] beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] num_beats;
  logic          busy;
  logic          in_valid;
  logic          in_ready;
  beat_t         in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
`ifdef MOD_REDUCE_RANGE_CHECK_EN
  logic          range_err;
`endif

  int checks = 0;
  int errors = 0;

  beat_t beats[$];

  always #5 clk = ~clk;

  mod_reduce_accumulator_ctrl #(
    .NTT_NUM (N),
    .DW      (DW),
    .Q       (Q),
    .CNT_W   (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_beats (num_beats),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef MOD_REDUCE_RANGE_CHECK_EN
    .range_err (range_err),
`endif
    .out_data  (out_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic beat_t fill(input int v);
    beat_t r;
    for (int k = 0; k < N; k++) r[DW*k +: DW] = v[DW-1:0];
    return r;
  endfunction

  function automatic beat_t rand_beat();
    beat_t r;
    int v;
    for (int k = 0; k < N; k++) begin
      v = $urandom_range(0, Q - 1);
      r[DW*k +: DW] = v[DW-1:0];
    end
    return r;
  endfunction

  function automatic longint model_sum();
    longint s;
    beat_t  bt;
    s = 0;
    foreach (beats[b]) begin
      bt = beats[b];
      for (int k = 0; k < N; k++) s += longint'(bt[DW*k +: DW]);
    end
    return s % Q;
  endfunction

  // gap < 0 picks a random 0..2 idle cycles before each beat.
  task automatic run_job(input int nb, input int gap, input int hold, input bit chk,
                         input string tag, output logic [DW-1:0] res);
    int            cnt;
    int            g;
    logic [DW-1:0] held;
    longint        exp;
    exp = model_sum();
    start = 1'b1;
    num_beats = nb[CW-1:0];
    tick();
    start = 1'b0;
    num_beats = '0;
    check({tag, "_busy_start"}, busy, 1);
    if (nb == 0) begin
      check({tag, "_zero_in_ready"}, in_ready, 0);
      check({tag, "_zero_out_valid"}, out_valid, 1);
    end else begin
      for (int b = 0; b < nb; b++) begin
        g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        for (int i = 0; i < g; i++) begin
          out_ready = 1'b1;          // must be ignored while no result
          tick();
          out_ready = 1'b0;
        end
        in_valid = 1'b1;
        in_data  = beats[b];
        if (b == 0) check({tag, "_in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
      end
      check({tag, "_in_ready_drop"}, in_ready, 0);
      cnt = 1;
      while (out_valid !== 1'b1 && cnt < 20) begin
        tick();
        cnt++;
      end
      check({tag, "_latency"}, cnt, 3);
    end
    held = out_data;
    for (int h = 0; h < hold; h++) begin
      start     = (h == 0);           // ignored outside IDLE
      num_beats = 16'd7;
      in_valid  = 1'b1;               // ignored while in_ready is low
      in_data   = fill(3);
      tick();
      start     = 1'b0;
      num_beats = '0;
      in_valid  = 1'b0;
    end
    if (hold > 0) begin
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_busy"}, busy, 1);
      check({tag, "_hold_stable"}, out_data, held);
    end
    if (chk) check({tag, "_data_model"}, out_data, exp);
    res = out_data;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_busy_done"}, busy, 0);
    check({tag, "_valid_done"}, out_valid, 0);
  endtask

  initial begin
    logic [DW-1:0] res;
    rst_n     = 1'b0;
    start     = 1'b0;
    num_beats = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
`ifdef MOD_REDUCE_RANGE_CHECK_EN
    check("rst_range_err", range_err, 0);
`endif
    rst_n = 1'b1;
    tick();

    // Single beat of all ones
    beats.delete();
    beats.push_back(fill(1));
    run_job(1, 0, 0, 1'b1, "single", res);
    check("single_value", res, 8);

    // Wrap: 16 lanes of Q-1
    beats.delete();
    beats.push_back(fill(Q - 1));
    beats.push_back(fill(Q - 1));
    run_job(2, 0, 0, 1'b1, "wrap", res);
    check("wrap_value", res, 12273);

    // Zero-beat job
    beats.delete();
    run_job(0, 0, 0, 1'b1, "zero", res);
    check("zero_value", res, 0);

    // Gapped input and held output
    beats.delete();
    for (int b = 0; b < 4; b++) beats.push_back(fill(b));
    run_job(4, 1, 5, 1'b1, "bp", res);
    check("bp_value", res, 48);

    // Mid-job reset after 2 of 5 beats
    start = 1'b1;
    num_beats = 16'd5;
    tick();
    start = 1'b0;
    num_beats = '0;
    for (int b = 0; b < 2; b++) begin
      in_valid = 1'b1;
      in_data  = fill(5);
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mrst_busy", busy, 0);
    check("mrst_in_ready", in_ready, 0);
    check("mrst_out_valid", out_valid, 0);
    check("mrst_out_data", out_data, 0);
    tick();
    check("mrst_out_data_later", out_data, 0);
    check("mrst_busy_later", busy, 0);
    beats.delete();
    beats.push_back(fill(2));
    run_job(1, 0, 0, 1'b1, "post_rst", res);
    check("post_rst_value", res, 16);

    // Randomized jobs against the reference sum
    for (int j = 0; j < 8; j++) begin
      int nb;
      nb = $urandom_range(1, 6);
      beats.delete();
      for (int b = 0; b < nb; b++) beats.push_back(rand_beat());
      run_job(nb, -1, $urandom_range(0, 3), 1'b1, $sformatf("rand%0d", j), res);
    end

`ifdef MOD_REDUCE_RANGE_CHECK_EN
    check("range_clean", range_err, 0);
    beats.delete();
    beats.push_back(fill(7));
    beats[0][DW*3 +: DW] = 14'd12289;
    run_job(1, 0, 2, 1'b0, "range_bad", res);
    check("range_set_sticky", range_err, 1);
    tick();
    check("range_still_set", range_err, 1);
    beats.delete();
    beats.push_back(fill(1));
    run_job(1, 0, 0, 1'b1, "range_next", res);
    check("range_cleared", range_err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
